// File: rtl/full_adder.sv
// full_adder: parameterizable ripple-carry adder built from per-bit full-adder
// cells, with a zero-latency combinational result and a one-cycle registered
// copy qualified by a valid flag.
//
// Optional feature macro: FULL_ADDER_OVERFLOW_EN
//   When defined, adds signed two's-complement overflow outputs ovf / ovf_q.
//
// Parameters:
//   WIDTH      operand width in bits, 1..64 (default 1 = classic full adder)
//
// Ports:
//   clk        rising-edge clock, registered path only
//   rst        synchronous active-high reset, clears registered path only
//   a, b       unsigned operands [WIDTH-1:0]
//   cin        carry-in to bit 0
//   in_valid   qualifies a/b/cin for capture into the registered path
//   sum        combinational a+b+cin modulo 2^WIDTH
//   carry      combinational carry-out of the MSB cell
//   sum_q      registered sum
//   carry_q    registered carry
//   out_valid  registered in_valid
//   ovf        (macro only) combinational signed overflow
//   ovf_q      (macro only) registered signed overflow
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
`ifdef FULL_ADDER_OVERFLOW_EN
  output logic             ovf,
  output logic             ovf_q,
`endif
  output logic             out_valid
);

  // c[i] is the carry into cell i; c[WIDTH] is the final carry-out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign sum   = s;
  assign carry = c[WIDTH];

`ifdef FULL_ADDER_OVERFLOW_EN
  // Carry into the MSB differs from carry out of it exactly when the signed
  // result does not fit. For WIDTH=1 the carry into the MSB is cin itself.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  // sum_q/carry_q hold when nothing is captured; out_valid is a one-cycle
  // pulse per captured sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
      ovf_q     <= 1'b0;
`endif
    end else if (in_valid) begin
      sum_q     <= sum;
      carry_q   <= carry;
      out_valid <= 1'b1;
`ifdef FULL_ADDER_OVERFLOW_EN
      ovf_q     <= ovf;
`endif
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
module tb_full_adder;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        in_valid;

  logic        sum1, carry1, sumq1, carryq1, ov1;
  logic [7:0]  sum8, sumq8;
  logic        carry8, carryq8, ov8;
  logic [15:0] sum16, sumq16;
  logic        carry16, carryq16, ov16;
`ifdef FULL_ADDER_OVERFLOW_EN
  logic        ovf1, ovfq1, ovf8, ovfq8, ovf16, ovfq16;
`endif

  int checks = 0;
  int errors = 0;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a[0:0]), .b(b[0:0]), .cin(cin), .in_valid(in_valid),
    .sum(sum1), .carry(carry1), .sum_q(sumq1), .carry_q(carryq1),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ovf1), .ovf_q(ovfq1),
`endif
    .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a[7:0]), .b(b[7:0]), .cin(cin), .in_valid(in_valid),
    .sum(sum8), .carry(carry8), .sum_q(sumq8), .carry_q(carryq8),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ovf8), .ovf_q(ovfq8),
`endif
    .out_valid(ov8)
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum16), .carry(carry16), .sum_q(sumq16), .carry_q(carryq16),
`ifdef FULL_ADDER_OVERFLOW_EN
    .ovf(ovf16), .ovf_q(ovfq16),
`endif
    .out_valid(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {carry,sum} for a w-bit adder, straight from integer arithmetic.
  function automatic logic [16:0] add_ref(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic ci);
    longint m, r;
    m = (longint'(1) << w) - 1;
    r = (longint'(x) & m) + (longint'(y) & m) + longint'(ci);
    return r[16:0];
  endfunction

  // Signed overflow: does the signed w-bit sum fall outside the w-bit range?
  function automatic logic ovf_ref(input int w, input logic [15:0] x,
                                   input logic [15:0] y, input logic ci);
    longint m, sx, sy, t, hi, lo;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (sx > (m >> 1)) sx = sx - (m + 1);
    if (sy > (m >> 1)) sy = sy - (m + 1);
    t  = sx + sy + longint'(ci);
    hi = m >> 1;
    lo = -hi - 1;
    return (t > hi) || (t < lo);
  endfunction

  // Registered-path model.
  logic [16:0] eq1, eq8, eq16;
  logic        eo1, eo8, eo16;
  logic        ev;
  logic        model_ready = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      eq1 = '0; eq8 = '0; eq16 = '0;
      eo1 = 1'b0; eo8 = 1'b0; eo16 = 1'b0;
      ev  = 1'b0;
      model_ready = 1'b1;
    end else if (in_valid) begin
      eq1  = add_ref(1, a, b, cin);
      eq8  = add_ref(8, a, b, cin);
      eq16 = add_ref(16, a, b, cin);
      eo1  = ovf_ref(1, a, b, cin);
      eo8  = ovf_ref(8, a, b, cin);
      eo16 = ovf_ref(16, a, b, cin);
      ev   = 1'b1;
    end else begin
      ev = 1'b0;
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    logic [16:0] e1, e8, e16;
    if (model_ready) begin
      e1  = add_ref(1, a, b, cin);
      e8  = add_ref(8, a, b, cin);
      e16 = add_ref(16, a, b, cin);
      chk("w1_comb",  {62'd0, carry1, sum1},    {47'd0, e1});
      chk("w8_comb",  {55'd0, carry8, sum8},    {47'd0, e8});
      chk("w16_comb", {47'd0, carry16, sum16},  {47'd0, e16});
      chk("w1_reg",   {62'd0, carryq1, sumq1},  {62'd0, eq1[1:0]});
      chk("w8_reg",   {55'd0, carryq8, sumq8},  {55'd0, eq8[8:0]});
      chk("w16_reg",  {47'd0, carryq16, sumq16}, {47'd0, eq16});
      chk("valid",    {61'd0, ov1, ov8, ov16},  {61'd0, ev, ev, ev});
`ifdef FULL_ADDER_OVERFLOW_EN
      chk("ovf_comb", {61'd0, ovf1, ovf8, ovf16},
          {61'd0, ovf_ref(1, a, b, cin), ovf_ref(8, a, b, cin), ovf_ref(16, a, b, cin)});
      chk("ovf_reg",  {61'd0, ovfq1, ovfq8, ovfq16}, {61'd0, eo1, eo8, eo16});
`endif
    end
  end

  task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input logic iv, input logic ir);
    @(posedge clk);
    #2;
    a = ia; b = ib; cin = ic; in_valid = iv; rst = ir;
  endtask

  initial begin
    logic [7:0] tt_sum;
    logic [7:0] tt_car;
    logic [2:0] v;
    tt_sum = 8'b1001_0110;
    tt_car = 8'b1110_1000;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;

    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    drive(16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("reset_out_valid", {63'd0, ov8}, 64'd0);
    chk("reset_sum_q", {56'd0, sumq8}, 64'd0);
    chk("reset_carry_q", {63'd0, carryq8}, 64'd0);

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive({15'd0, v[2]}, {15'd0, v[1]}, v[0], 1'b1, 1'b0);
      #1;
      chk($sformatf("tt%0d_sum", i), {63'd0, sum1}, {63'd0, tt_sum[i]});
      chk($sformatf("tt%0d_carry", i), {63'd0, carry1}, {63'd0, tt_car[i]});
    end

    // WIDTH=8 wrap and carry-in only
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    #1;
    chk("w8_wrap_sum", {56'd0, sum8}, 64'h00);
    chk("w8_wrap_carry", {63'd0, carry8}, 64'd1);
    drive(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    #1;
    chk("w8_cin_sum", {56'd0, sum8}, 64'h01);
    chk("w8_cin_carry", {63'd0, carry8}, 64'd0);

    // Registered path: capture, then hold
    drive(16'h0012, 16'h0034, 1'b1, 1'b1, 1'b0);
    drive(16'h0055, 16'h0066, 1'b0, 1'b0, 1'b0);
    #1;
    chk("cap_sum_q", {56'd0, sumq8}, 64'h47);
    chk("cap_carry_q", {63'd0, carryq8}, 64'd0);
    chk("cap_out_valid", {63'd0, ov8}, 64'd1);
    drive(16'h0055, 16'h0066, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hold_out_valid", {63'd0, ov8}, 64'd0);
    chk("hold_sum_q", {56'd0, sumq8}, 64'h47);

    // Reset wins over a simultaneous in_valid
    drive(16'h0010, 16'h0020, 1'b0, 1'b1, 1'b1);
    #1;
    chk("rst_comb_sum", {56'd0, sum8}, 64'h30);
    drive(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_sum_q", {56'd0, sumq8}, 64'd0);
    chk("rst_out_valid", {63'd0, ov8}, 64'd0);
    chk("rst_comb_sum_after", {56'd0, sum8}, 64'h30);

`ifdef FULL_ADDER_OVERFLOW_EN
    drive(16'h007F, 16'h0001, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_pos_sum", {56'd0, sum8}, 64'h80);
    chk("ovf_pos_carry", {63'd0, carry8}, 64'd0);
    chk("ovf_pos_ovf", {63'd0, ovf8}, 64'd1);
    drive(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ovf_neg_ovf", {63'd0, ovf8}, 64'd0);
    chk("ovf_neg_carry", {63'd0, carry8}, 64'd1);
`endif

    // Random WIDTH=16 vectors, occasional idle cycles and mid-stream resets
    for (int n = 0; n < 1000; n++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Parameterizable ripple-carry adder built from per-bit full-adder cells.
- Combinational outputs are zero-latency. A parallel registered copy with a valid flag lets pipelined datapaths consume the result one cycle later.
- Default WIDTH=1 gives the classic 1-bit full adder (a, b, cin -> sum, carry).
- Used as a leaf arithmetic primitive in combinational and pipelined datapaths.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock for the registered path only
- rst  input  1  synchronous active-high reset; clears the registered path only
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- cin  input  1  carry-in to bit 0
- in_valid  input  1  qualifies a/b/cin for capture into the registered path
- sum  output  WIDTH  combinational sum, a+b+cin modulo 2^WIDTH
- carry  output  1  combinational carry-out from the MSB cell
- sum_q  output  WIDTH  registered sum
- carry_q  output  1  registered carry
- out_valid  output  1  registered in_valid

Behaviour:
- Bit cell i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = cin
- Combinational outputs:
  - sum = s[WIDTH-1:0]; carry = c[WIDTH].
  - Equivalent to {carry,sum} = a + b + cin, computed at WIDTH+1 bits.
  - Zero latency; no clock or reset dependency; outputs follow any input change in the same delta.
- WIDTH=1 truth table, inputs a b cin -> outputs sum carry:
  - 000 -> 0 0
  - 001 -> 1 0
  - 010 -> 1 0
  - 011 -> 0 1
  - 100 -> 1 0
  - 101 -> 0 1
  - 110 -> 0 1
  - 111 -> 1 1
- Wrap-around: the result is truncated modulo 2^WIDTH; the overflow is reported only through carry.
- Registered path, evaluated on each rising clk edge:
  - If rst: sum_q=0, carry_q=0, out_valid=0.
  - Else if in_valid: sum_q<=sum, carry_q<=carry, out_valid<=1.
  - Else: sum_q and carry_q hold; out_valid<=0.
- Latency: 1 cycle from an in_valid sample to out_valid/sum_q.
- Reset has priority over a simultaneous in_valid. Reset mid-stream drops the in-flight result and does not affect the combinational outputs.
- Reset values of every registered output: 0. Combinational outputs have no reset value.
- X on any input bit propagates to the affected sum bits and the carry chain; no X-masking.

Optional Feature:
- Macro FULL_ADDER_OVERFLOW_EN.
- Defined:
  - Adds output port ovf (1 bit, combinational) and ovf_q (1 bit, registered).
  - ovf = c[WIDTH] ^ c[WIDTH-1], which is signed two's-complement overflow. For WIDTH=1, c[0]=cin is used.
  - ovf_q follows the same capture, hold and reset rules as carry_q; its reset value is 0.
- Undefined: ports ovf and ovf_q do not exist; no extra logic.

Test Plan:
- WIDTH=1: apply all 8 {a,b,cin} combos, stepping 10 ns each -> sum/carry match the truth table; e.g. 111 -> sum=1 carry=1, 011 -> sum=0 carry=1.
- WIDTH=8: a=0xFF, b=0x01, cin=0 -> sum=0x00, carry=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, carry=0.
- Registered path, WIDTH=8:
  - Cycle 0: in_valid=1 with a=0x12, b=0x34, cin=1.
  - Cycle 1: sum_q=0x47, carry_q=0, out_valid=1.
  - Next cycle, in_valid=0: out_valid=0 and sum_q holds 0x47.
- Reset: assert rst together with in_valid=1 -> next edge gives sum_q=0, carry_q=0, out_valid=0, while combinational sum is still correct.
- Random WIDTH=16, 1000 vectors -> {carry,sum} == a+b+cin every vector; the registered outputs match the same vector one cycle later.
- With FULL_ADDER_OVERFLOW_EN, WIDTH=8:
  - a=0x7F, b=0x01, cin=0 -> sum=0x80, carry=0, ovf=1.
  - a=0xFF, b=0x01 -> ovf=0, carry=1.
